dec_expgob: RTL
===============

DEC_EXPGOB -- requirements
Module: dec_expgob

Interface
REQ-001 SHALL have one clock and a reset: clk input 1 rising-edge clock; rst input 1 reset, synchronous and active-high.
REQ-002 SHALL have bit_i input 1: serial Exp-Golomb code bit, MSB-first, the same stream format the encoder emits.
REQ-003 SHALL have bit_vld_i input 1: bit_i qualifier; one bit consumed per cycle it is high.
REQ-004 SHALL have clr_i input 1: synchronous clear of the error condition.
REQ-005 SHALL have dt_o output 8: decoded value, codeNum 0..255.
REQ-006 SHALL have dt_vld_o output 1: one-cycle pulse marking dt_o valid.
REQ-007 SHALL have busy_o output 1: high while a codeword is partially received.
REQ-008 SHALL have err_o output 1: sticky prefix-overflow flag.

Function
REQ-009 SHALL implement FSM states PREFIX, SUFFIX, ERR; PREFIX after reset.
REQ-010 SHALL always accept bit_vld_i, with no backpressure; cycles with bit_vld_i low SHALL leave all state unchanged.
REQ-011 In PREFIX, bit 0 SHALL increment a 4-bit zero counter zcnt.
REQ-012 In PREFIX, bit 0 arriving with zcnt==8 SHALL move to ERR, since nine leading zeros is illegal for an 8-bit value.
REQ-013 In PREFIX, bit 1 SHALL load a 9-bit accumulator acc=1 and set remaining=zcnt.
REQ-014 If remaining==0 after REQ-013, the codeword is complete; otherwise the FSM SHALL enter SUFFIX.
REQ-015 In SUFFIX, each bit SHALL do acc={acc[7:0],bit_i} and remaining-=1; remaining reaching 0 completes the codeword.
REQ-016 On completion, the cycle after the last bit is accepted, dt_o SHALL be registered as (acc-1)[7:0], dt_vld_o SHALL be high for exactly 1 cycle, and the FSM SHALL return to PREFIX with zcnt=0; latency is 1 clk from the final bit.
REQ-017 dt_o SHALL hold its last value until the next completion.
REQ-018 Back-to-back codewords SHALL be supported: a bit accepted in the same cycle dt_vld_o is high belongs to the next codeword.
REQ-019 busy_o SHALL be 1 when zcnt!=0 or the state is SUFFIX, else 0.
REQ-020 ERR SHALL assert err_o, ignore bit_i, and hold dt_vld_o=0; only clr_i or rst leaves ERR, returning to PREFIX with zcnt=0.
REQ-021 clr_i in PREFIX or SUFFIX SHALL abort any partial codeword, return to PREFIX, and produce no output.
REQ-022 If clr_i and bit_vld_i are high together, clr_i SHALL win and the bit is dropped.

Reset
REQ-023 rst SHALL force state=PREFIX, zcnt=0, acc=0, remaining=0, dt_o=0, dt_vld_o=0, busy_o=0, err_o=0, and len_o=0 when present.
REQ-024 rst asserted mid-codeword SHALL discard the partial codeword; rst SHALL have priority over clr_i and bit_vld_i.

Configuration
REQ-025 Macro DEC_EXPGOB_LEN_EN defined SHALL add output len_o (5 bits, codeword length 2*zcnt+1, range 1..17), registered and valid with dt_vld_o.
REQ-026 Without DEC_EXPGOB_LEN_EN, len_o and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-027 Package expgob_pkg SHALL hold DW=8, MAX_ZEROS=8, and the FSM state enum typedef, shared with the encoder side.
REQ-028 The block SHALL be a single module with no sub-module; the prefix counter and suffix shifter are inline.

Verification
REQ-029 Stream "1","010","011","00100" with bit_vld_i high every cycle SHALL give dt_vld_o pulses with dt_o=0,1,2,3, each pulse 1 cycle after the final bit, and no idle gap required between codewords.
REQ-030 Eight 0s, then 1, then eight 0s SHALL give dt_o=255, with len_o=17 when DEC_EXPGOB_LEN_EN is defined.
REQ-031 "00111" with bit_vld_i low for 3 cycles between every bit SHALL give dt_o=6; busy_o SHALL be high from the first 0 until the pulse.
REQ-032 Nine consecutive 0s SHALL set err_o=1 on the cycle after the 9th bit; further bits SHALL produce no dt_vld_o; clr_i SHALL drop err_o, after which "1" decodes to 0.
REQ-033 rst pulsed after "001" of "00110" SHALL clear all outputs to 0; a following "010" SHALL decode to 1.

Source files
------------

// File: rtl/expgob_pkg.sv
// Shared Exp-Golomb definitions for the encoder and decoder sides:
// data width, longest legal zero prefix, and the decoder FSM state type.
package expgob_pkg;

  localparam int DW        = 8;       // decoded value width (codeNum 0..255)
  localparam int MAX_ZEROS = 8;       // longest legal zero prefix for DW bits
  localparam int ZW        = 4;       // zero counter / remaining-bits width
  localparam int AW        = DW + 1;  // accumulator holds the leading 1 plus DW bits
  localparam int LW        = 5;       // codeword length 1..17

  typedef enum logic [1:0] {
    ST_PREFIX = 2'd0,
    ST_SUFFIX = 2'd1,
    ST_ERR    = 2'd2
  } state_e;

endpackage

// File: rtl/dec_expgob_if.sv
// Serial-bit input and decoded-value output bundle of the Exp-Golomb decoder.
// Optional: DEC_EXPGOB_LEN_EN adds len_o (codeword length).
interface dec_expgob_if;
  import expgob_pkg::*;

  logic          bit_i;
  logic          bit_vld_i;
  logic          clr_i;
  logic [DW-1:0] dt_o;
  logic          dt_vld_o;
  logic          busy_o;
  logic          err_o;
`ifdef DEC_EXPGOB_LEN_EN
  logic [LW-1:0] len_o;

  modport master (output bit_i, bit_vld_i, clr_i,
                  input  dt_o, dt_vld_o, busy_o, err_o, len_o);
  modport slave  (input  bit_i, bit_vld_i, clr_i,
                  output dt_o, dt_vld_o, busy_o, err_o, len_o);
`else
  modport master (output bit_i, bit_vld_i, clr_i,
                  input  dt_o, dt_vld_o, busy_o, err_o);
  modport slave  (input  bit_i, bit_vld_i, clr_i,
                  output dt_o, dt_vld_o, busy_o, err_o);
`endif

endinterface

// File: rtl/dec_expgob.sv
// Serial Exp-Golomb decoder: counts the zero prefix, shifts in the suffix,
// and emits codeNum = acc-1 one clock after the final bit.
// Optional: DEC_EXPGOB_LEN_EN adds a registered codeword length output.
module dec_expgob
  import expgob_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  dec_expgob_if.slave bus
);

  state_e        state_q, state_d;
  logic [ZW-1:0] zcnt_q, zcnt_d;
  logic [ZW-1:0] rem_q, rem_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [DW-1:0] dt_q, dt_d;
  logic          dt_vld_q, dt_vld_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          done;
`ifdef DEC_EXPGOB_LEN_EN
  logic [LW-1:0] len_q, len_d;
`endif

  // Next-state: prefix counting, suffix shifting, completion and error handling.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    zcnt_d   = zcnt_q;
    rem_d    = rem_q;
    acc_d    = acc_q;
    dt_d     = dt_q;
    dt_vld_d = 1'b0;
    done     = 1'b0;
`ifdef DEC_EXPGOB_LEN_EN
    len_d    = len_q;
`endif

    if (bus.clr_i) begin
      // Clear wins over a simultaneous bit; any partial codeword is dropped.
      state_d = ST_PREFIX;
      zcnt_d  = '0;
      rem_d   = '0;
      acc_d   = '0;
    end else if (bus.bit_vld_i) begin
      unique case (state_q)
        ST_PREFIX: begin
          if (!bus.bit_i) begin
            if (zcnt_q == ZW'(MAX_ZEROS)) begin
              state_d = ST_ERR;
              zcnt_d  = '0;
            end else begin
              zcnt_d = zcnt_q + 1'b1;
            end
          end else begin
            acc_d = AW'(1);
            rem_d = zcnt_q;
            if (zcnt_q == '0) done = 1'b1;
            else              state_d = ST_SUFFIX;
          end
        end
        ST_SUFFIX: begin
          acc_d = {acc_q[DW-1:0], bus.bit_i};
          rem_d = rem_q - 1'b1;
          if (rem_q == ZW'(1)) done = 1'b1;
        end
        default: ; // ST_ERR ignores bits until clr_i or rst
      endcase
    end

    if (done) begin
      // (acc-1)[7:0] equals acc[7:0]-1 modulo 256, so the 9th bit is not needed.
      dt_d     = acc_d[DW-1:0] - 1'b1;
      dt_vld_d = 1'b1;
      state_d  = ST_PREFIX;
      zcnt_d   = '0;
`ifdef DEC_EXPGOB_LEN_EN
      len_d    = {zcnt_q, 1'b1};  // 2*zeros + 1
`endif
    end

    busy_d = (zcnt_d != '0) || (state_d == ST_SUFFIX);
    err_d  = (state_d == ST_ERR);
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q  <= ST_PREFIX;
      zcnt_q   <= '0;
      rem_q    <= '0;
      acc_q    <= '0;
      dt_q     <= '0;
      dt_vld_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef DEC_EXPGOB_LEN_EN
      len_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      zcnt_q   <= zcnt_d;
      rem_q    <= rem_d;
      acc_q    <= acc_d;
      dt_q     <= dt_d;
      dt_vld_q <= dt_vld_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
`ifdef DEC_EXPGOB_LEN_EN
      len_q    <= len_d;
`endif
    end
  end

  assign bus.dt_o     = dt_q;
  assign bus.dt_vld_o = dt_vld_q;
  assign bus.busy_o   = busy_q;
  assign bus.err_o    = err_q;
`ifdef DEC_EXPGOB_LEN_EN
  assign bus.len_o    = len_q;
`endif

endmodule
